// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide/remainder controller: radix-2 restoring loop with
// sign fix-up, valid/ready on both request and response sides.
module div_sequencer #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]      state_reg, state_next;
    logic            rem_sel_reg, rem_sel_next;
    logic            sgn_reg, sgn_next;
    logic [XLEN-1:0] rs1_reg, rs1_next;
    logic [XLEN-1:0] rs2_reg, rs2_next;
    logic [XLEN-1:0] dvd_reg, dvd_next;
    logic [XLEN-1:0] dvs_reg, dvs_next;
    logic [XLEN-1:0] rem_reg, rem_next;
    logic [XLEN-1:0] quo_reg, quo_next;
    logic [5:0]      cnt_reg, cnt_next;
    logic            q_neg_reg, q_neg_next;
    logic            r_neg_reg, r_neg_next;
    logic [XLEN-1:0] result_reg, result_next;

    function automatic logic [XLEN-1:0] twos_comp(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    function automatic logic is_special(input logic sgn, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        return (b == '0) ||
               (sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1));
    endfunction

    // Divide-by-zero takes priority; the only other special case is signed overflow.
    function automatic logic [XLEN-1:0] special_result(input logic rem_sel,
                                                       input logic [XLEN-1:0] a,
                                                       input logic [XLEN-1:0] b);
        if (b == '0)
            return rem_sel ? a : '1;
        else
            return rem_sel ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    endfunction

    logic [XLEN-1:0] opnd [2];
    logic [XLEN-1:0] mag  [2];

    assign opnd[0] = rs1_reg;
    assign opnd[1] = rs2_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mag
            assign mag[gi] = (sgn_reg && opnd[gi][XLEN-1]) ? twos_comp(opnd[gi]) : opnd[gi];
        end
    endgenerate

    // The restored partial remainder is always below dvs, so its 33rd bit is
    // only ever non-zero transiently inside rem_t.
    logic [XLEN:0]   rem_t;
    logic            rem_ge;
    logic [XLEN-1:0] rem_diff;
    logic [XLEN-1:0] quo_res;
    logic [XLEN-1:0] rem_res;

    assign rem_t    = {rem_reg, dvd_reg[XLEN-1]};
    assign rem_ge   = rem_t >= {1'b0, dvs_reg};
    assign rem_diff = rem_t[XLEN-1:0] - dvs_reg;
    assign quo_res  = q_neg_reg ? twos_comp(quo_reg) : quo_reg;
    assign rem_res  = r_neg_reg ? twos_comp(rem_reg) : rem_reg;

    always_comb begin
        state_next   = state_reg;
        rem_sel_next = rem_sel_reg;
        sgn_next     = sgn_reg;
        rs1_next     = rs1_reg;
        rs2_next     = rs2_reg;
        dvd_next     = dvd_reg;
        dvs_next     = dvs_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        cnt_next     = cnt_reg;
        q_neg_next   = q_neg_reg;
        r_neg_next   = r_neg_reg;
        result_next  = result_reg;

        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        rem_sel_next = req_op[1];
                        sgn_next     = ~req_op[0];
                        rs1_next     = req_rs1;
                        rs2_next     = req_rs2;
                        if (EARLY_OUT && is_special(~req_op[0], req_rs1, req_rs2)) begin
                            result_next = special_result(req_op[1], req_rs1, req_rs2);
                            state_next  = S_DONE;
                        end else begin
                            state_next = S_PREP;
                        end
                    end
                end
                S_PREP: begin
                    dvd_next   = mag[0];
                    dvs_next   = mag[1];
                    q_neg_next = sgn_reg && (rs1_reg[XLEN-1] ^ rs2_reg[XLEN-1]);
                    r_neg_next = sgn_reg && rs1_reg[XLEN-1];
                    rem_next   = '0;
                    quo_next   = '0;
                    cnt_next   = '0;
                    state_next = S_ITER;
                end
                S_ITER: begin
                    dvd_next = {dvd_reg[XLEN-2:0], 1'b0};
                    rem_next = rem_ge ? rem_diff : rem_t[XLEN-1:0];
                    quo_next = {quo_reg[XLEN-2:0], rem_ge};
                    cnt_next = cnt_reg + 6'd1;
                    if (cnt_reg == 6'(XLEN-1))
                        state_next = S_FIX;
                end
                S_FIX: begin
                    // The loop alone gets signed x/0 wrong when x<0, so special
                    // cases are overridden here as well.
                    if (is_special(sgn_reg, rs1_reg, rs2_reg))
                        result_next = special_result(rem_sel_reg, rs1_reg, rs2_reg);
                    else
                        result_next = rem_sel_reg ? rem_res : quo_res;
                    state_next = S_DONE;
                end
                S_DONE: begin
                    if (resp_ready)
                        state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            rem_sel_reg <= 1'b0;
            sgn_reg     <= 1'b0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            cnt_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            result_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            rem_sel_reg <= rem_sel_next;
            sgn_reg     <= sgn_next;
            rs1_reg     <= rs1_next;
            rs2_reg     <= rs2_next;
            dvd_reg     <= dvd_next;
            dvs_reg     <= dvs_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            cnt_reg     <= cnt_next;
            q_neg_reg   <= q_neg_next;
            r_neg_reg   <= r_neg_next;
            result_reg  <= result_next;
        end
    end

    assign req_ready   = (state_reg == S_IDLE) && !flush;
    assign resp_valid  = (state_reg == S_DONE);
    assign resp_result = result_reg;
    assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: one early-out instance and one iterating
// instance, hand-computed results and latencies.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid0 = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic        resp_ready = 1'b1;

    logic        req_ready, resp_valid, busy;
    logic [31:0] resp_result;
    logic        req_ready0, resp_valid0, busy0;
    logic [31:0] resp_result0;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .busy(busy)
    );

    div_sequencer #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_result(resp_result0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request/response with resp_ready high; lat counts edges after the
    // accepting edge until resp_valid is seen.
    task automatic do_op(input bit use0, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input string tag);
        int lat;
        @(negedge clk);
        req_op = op; req_rs1 = a; req_rs2 = b;
        if (use0) req_valid0 = 1'b1; else req_valid = 1'b1;
        #1 chk({tag, " req_ready"}, use0 ? req_ready0 : req_ready, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        lat = 0;
        while (!(use0 ? resp_valid0 : resp_valid) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, use0 ? resp_result0 : resp_result, exp);
        @(posedge clk); #1;
        chk({tag, " idle after"}, use0 ? busy0 : busy, 32'd0);
        $display("op=%0d a=%h b=%h -> %h lat=%0d (%s)", op, a, b,
                 use0 ? resp_result0 : resp_result, lat, tag);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        #1;
        chk("rst resp_valid", resp_valid, 32'd0);
        chk("rst resp_result", resp_result, 32'd0);
        chk("rst busy", busy, 32'd0);
        chk("rst req_ready", req_ready, 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 2'b01, 32'd100, 32'd7, 32'd14, 34, "DIVU 100/7");
        do_op(0, 2'b11, 32'd100, 32'd7, 32'd2, 34, "REMU 100/7");
        do_op(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "DIV -7/2");
        do_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "REM -7/2");

        do_op(0, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "DIV 5/0 early");
        do_op(0, 2'b11, 32'd5, 32'd0, 32'd5, 0, "REMU 5/0 early");
        do_op(1, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 34, "DIV 5/0 iter");
        do_op(1, 2'b11, 32'd5, 32'd0, 32'd5, 34, "REMU 5/0 iter");
        do_op(1, 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 34, "DIV -5/0 iter");
        do_op(1, 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 34, "REM -5/0 iter");

        do_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "DIV ovf early");
        do_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "REM ovf early");
        do_op(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "DIV ovf iter");
        do_op(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "REM ovf iter");

        // Backpressure in DONE.
        @(negedge clk);
        resp_ready = 1'b0;
        req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", lat, 34);
        held = resp_result;
        chk("bp result", held, 32'd142);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp resp_valid held", resp_valid, 32'd1);
            chk("bp resp_result held", resp_result, 32'd142);
            chk("bp req_ready low", req_ready, 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp released valid", resp_valid, 32'd0);
        chk("bp released req_ready", req_ready, 32'd1);
        $display("backpressure: result=%h held 10 cycles", held);

        // Flush at ITER cnt=15 with a competing request.
        @(negedge clk);
        req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_op = 2'b11;
        #1 chk("flush req_ready", req_ready, 32'd0);
        @(posedge clk); #1;
        chk("flush busy", busy, 32'd0);
        chk("flush resp_valid", resp_valid, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("post-flush req_ready", req_ready, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("post-flush accepted", busy, 32'd1);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("post-flush latency", lat, 34);
        chk("post-flush REMU 1000/3", resp_result, 32'd1);
        $display("flush: next op REMU 1000/3 -> %h", resp_result);
        @(posedge clk); #1;

        // Asynchronous reset mid-ITER.
        @(negedge clk);
        req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst resp_valid", resp_valid, 32'd0);
        chk("arst resp_result", resp_result, 32'd0);
        chk("arst busy", busy, 32'd0);
        chk("arst req_ready", req_ready, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("arst no stale resp", resp_valid, 32'd0);
        $display("async reset mid-ITER: outputs cleared");

        do_op(0, 2'b01, 32'd1000, 32'd3, 32'd333, 34, "DIVU 1000/3 after reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
